// File: rtl/nf10_upb_interconnect_tx_framer.sv
// nf10_upb_interconnect_tx_framer
//
// Sits between the output queue and the interconnect s_axis input. The
// module puts one header word in front of every AXIS packet. The header
// carries the tuser metadata and a per-packet sequence number, because the
// serial link has no tuser sideband. While the packet passes through, the
// module adds up the byte enables and compares the total with the declared
// packet length. It keeps a packet counter and a length-error counter.
//
// Ports
//   axi_aclk, RESET              clock; synchronous active-high reset
//   s_axis_*                     input packet stream (tuser valid on first beat)
//   m_axis_tdata/tkeep/tlast     framed output stream, one register stage
//   m_axis_tuser_hdr             1 while the output word is a header
//   m_axis_tvalid/tready         output handshake
//   pkt_count                    headers emitted (wraps)
//   len_err_count                length mismatches (saturates at 255)
//
// Handshake: a word moves on a rising edge where valid && ready are both
// high. A producer holds valid and its payload until that edge. The output
// register may load when it is empty or being drained
// (load_ok = !m_axis_tvalid || m_axis_tready). s_axis_tready is a
// combinational function of state, m_axis_tvalid and m_axis_tready. It is
// never high in IDLE. In IDLE the first beat is only examined to build the
// header. The same beat is then accepted one cycle later, in DATA.

module nf10_upb_interconnect_tx_framer #(
  parameter int          C_DATA_WIDTH = 256,
  parameter logic [31:0] HDR_MAGIC    = 32'h55504231,
  parameter int          SEQ_WIDTH    = 16
) (
  input  logic                      axi_aclk,
  input  logic                      RESET,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [13:0]               s_axis_tuser_packet_length,
  input  logic [2:0]                s_axis_tuser_in_port,
  input  logic [7:0]                s_axis_tuser_out_port,
  input  logic [2:0]                s_axis_tuser_in_vport,
  input  logic [7:0]                s_axis_tuser_out_vport,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                      m_axis_tuser_hdr,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [31:0]               pkt_count,
  output logic [7:0]                len_err_count
);

  localparam int KEEP_W = C_DATA_WIDTH / 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  logic [0:0]           state;
  logic [SEQ_WIDTH-1:0] seq;
  logic [13:0]          len_lat;
  logic [14:0]          byte_cnt;

  logic                    load_ok;
  logic                    take_hdr;
  logic                    take_beat;
  logic [5:0]              beat_bytes;
  logic [15:0]             byte_sum;
  logic [14:0]             byte_next;
  logic [C_DATA_WIDTH-1:0] hdr_word;

  // Count of set byte enables. Non-contiguous patterns are counted as they are.
  function automatic logic [5:0] popcount(input logic [KEEP_W-1:0] k);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      n = n + {5'd0, k[i]};
    end
    return n;
  endfunction

  assign load_ok       = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == ST_DATA) && load_ok;
  assign take_hdr      = (state == ST_IDLE) && s_axis_tvalid && load_ok;
  assign take_beat     = (state == ST_DATA) && s_axis_tvalid && s_axis_tready;

  // The byte count saturates, so a very long packet cannot wrap back to a
  // value that matches its declared length by accident.
  assign beat_bytes = popcount(s_axis_tkeep);
  assign byte_sum   = {1'b0, byte_cnt} + {10'd0, beat_bytes};
  assign byte_next  = byte_sum[15] ? 15'h7FFF : byte_sum[14:0];

  always_comb begin
    hdr_word                     = '0;
    hdr_word[13:0]               = s_axis_tuser_packet_length;
    hdr_word[16:14]              = s_axis_tuser_in_port;
    hdr_word[24:17]              = s_axis_tuser_out_port;
    hdr_word[27:25]              = s_axis_tuser_in_vport;
    hdr_word[35:28]              = s_axis_tuser_out_vport;
    hdr_word[36 +: SEQ_WIDTH]    = seq;
    hdr_word[95:64]              = HDR_MAGIC;
  end

  always_ff @(posedge axi_aclk) begin
    if (RESET) begin
      state            <= ST_IDLE;
      seq              <= '0;
      len_lat          <= '0;
      byte_cnt         <= '0;
      pkt_count        <= '0;
      len_err_count    <= '0;
      m_axis_tdata     <= '0;
      m_axis_tkeep     <= '0;
      m_axis_tuser_hdr <= 1'b0;
      m_axis_tvalid    <= 1'b0;
      m_axis_tlast     <= 1'b0;
    end else begin
      if (take_hdr) begin
        m_axis_tdata     <= hdr_word;
        m_axis_tkeep     <= '1;
        m_axis_tuser_hdr <= 1'b1;
        m_axis_tlast     <= 1'b0;
        m_axis_tvalid    <= 1'b1;
        len_lat          <= s_axis_tuser_packet_length;
        seq              <= seq + 1'b1;
        pkt_count        <= pkt_count + 32'd1;
        byte_cnt         <= '0;
        state            <= ST_DATA;
      end else if (take_beat) begin
        m_axis_tdata     <= s_axis_tdata;
        m_axis_tkeep     <= s_axis_tkeep;
        m_axis_tuser_hdr <= 1'b0;
        m_axis_tlast     <= s_axis_tlast;
        m_axis_tvalid    <= 1'b1;
        byte_cnt         <= byte_next;
        if (s_axis_tlast) begin
          // A mismatched packet is still forwarded. The mismatch is only counted.
          if ((byte_next != {1'b0, len_lat}) && (len_err_count != 8'hFF)) begin
            len_err_count <= len_err_count + 8'd1;
          end
          state <= ST_IDLE;
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nf10_upb_interconnect_tx_framer.sv
// Testbench for nf10_upb_interconnect_tx_framer.
// The sequence width is reduced to 8 bits so the wrap case runs in a few hundred cycles.

module tb_nf10_upb_interconnect_tx_framer;

  localparam int          SEQ_W = 8;
  localparam logic [31:0] MAGIC = 32'h55504231;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic [13:0]  s_len;
  logic [2:0]   s_ip;
  logic [7:0]   s_op;
  logic [2:0]   s_ivp;
  logic [7:0]   s_ovp;
  logic         s_tvalid, s_tlast, s_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic         m_hdr, m_tvalid, m_tlast, m_tready;
  logic [31:0]  pkt_count;
  logic [7:0]   len_err_count;

  nf10_upb_interconnect_tx_framer #(
    .C_DATA_WIDTH(256), .HDR_MAGIC(MAGIC), .SEQ_WIDTH(SEQ_W)
  ) dut (
    .axi_aclk(clk), .RESET(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tuser_packet_length(s_len), .s_axis_tuser_in_port(s_ip),
    .s_axis_tuser_out_port(s_op), .s_axis_tuser_in_vport(s_ivp),
    .s_axis_tuser_out_vport(s_ovp),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser_hdr(m_hdr),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .pkt_count(pkt_count), .len_err_count(len_err_count)
  );

  // ---------------- scoreboard state / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [289:0] exp_q[$];          // {hdr, last, keep[31:0], data[255:0]}
  int           model_seq  = 0;
  logic [31:0]  model_pkts = 0;
  int           model_lerr = 0;
  int           rdy_mode   = 0;    // 0: always ready, 1: toggle, 2: random
  logic [255:0] bd[$];
  logic [31:0]  bk[$];
  logic [13:0]  p_len;
  logic [2:0]   p_ip, p_ivp;
  logic [7:0]   p_op, p_ovp;

  task automatic check(input string tag, input logic [289:0] got, input logic [289:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic report_finish();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  function automatic logic [289:0] out_word();
    return {m_hdr, m_tlast, m_tkeep, m_tdata};
  endfunction

  function automatic logic [255:0] rand_data();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // ---------------- output monitor ----------------
  initial begin
    logic         stalled;
    logic [289:0] stall_word;
    stalled = 1'b0;
    stall_word = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid", m_tvalid, 1);
          check("stall_hold", out_word(), stall_word);
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) check("extra_word", exp_q.size(), 1);
          else check("word", out_word(), exp_q.pop_front());
        end
        stalled    = m_tvalid && !m_tready;
        stall_word = out_word();
      end
    end
  end

  // ---------------- m_axis_tready driver ----------------
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = !m_tready;
        default: m_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  // Builds one packet from its byte length and pushes the expected frame.
  task automatic prepare_pkt(input int nbytes, input int decl, input int op_force);
    int nb, rem;
    logic [289:0] h;
    logic [31:0]  k;
    nb    = (nbytes + 31) / 32;
    rem   = nbytes % 32;
    p_len = 14'(decl);
    p_ip  = 3'($urandom);
    p_op  = (op_force >= 0) ? 8'(op_force) : 8'($urandom);
    p_ivp = 3'($urandom);
    p_ovp = 8'($urandom);
    h = '0;
    h[289]            = 1'b1;
    h[287:256]        = 32'hFFFF_FFFF;
    h[13:0]           = p_len;
    h[16:14]          = p_ip;
    h[24:17]          = p_op;
    h[27:25]          = p_ivp;
    h[35:28]          = p_ovp;
    h[36 +: SEQ_W]    = SEQ_W'(model_seq);
    h[95:64]          = MAGIC;
    exp_q.push_back(h);
    model_seq  = (model_seq + 1) % (1 << SEQ_W);
    model_pkts = model_pkts + 1;
    if (nbytes != decl && model_lerr < 255) model_lerr++;
    bd.delete();
    bk.delete();
    for (int i = 0; i < nb; i++) begin
      k = (i == nb - 1 && rem != 0) ? 32'((64'd1 << rem) - 1) : 32'hFFFF_FFFF;
      bd.push_back(rand_data());
      bk.push_back(k);
      exp_q.push_back({1'b0, (i == nb - 1), k, bd[i]});
    end
  endtask

  // Presents beat i and holds it until the handshake edge; returns cycles spent.
  task automatic drive_beat(input int i, output int cyc);
    logic hs;
    s_tvalid = 1'b1;
    s_tdata  = bd[i];
    s_tkeep  = bk[i];
    s_tlast  = (i == bd.size() - 1);
    if (i == 0) begin
      s_len = p_len; s_ip = p_ip; s_op = p_op; s_ivp = p_ivp; s_ovp = p_ovp;
    end else begin
      s_len = 14'($urandom); s_ip = 3'($urandom); s_op = 8'($urandom);
      s_ivp = 3'($urandom); s_ovp = 8'($urandom);
    end
    cyc = 0;
    forever begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) break;
      if (cyc > 1000) begin
        check("hs_timeout", cyc, 0);
        report_finish();
      end
    end
  endtask

  task automatic send_pkt(input int nbytes, input int decl, input int op_force, output int cycles);
    int c;
    prepare_pkt(nbytes, decl, op_force);
    cycles = 0;
    for (int i = 0; i < bd.size(); i++) begin
      drive_beat(i, c);
      cycles += c;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    rst = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;
    s_len = '0; s_ip = '0; s_op = '0; s_ivp = '0; s_ovp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {m_tvalid, out_word()}, '0);
    check("rst_sready", s_tready, 0);
    check("rst_pkts", pkt_count, 0);
    check("rst_lerr", len_err_count, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 64 B packet, out_port 4
    rdy_mode = 0;
    send_pkt(64, 64, 4, cyc);
    drain();
    check("t1_pkts", pkt_count, model_pkts);
    check("t1_lerr", len_err_count, model_lerr);

    // three back-to-back 97 B packets: one bubble per packet
    for (int p = 0; p < 3; p++) begin
      send_pkt(97, 97, -1, cyc);
      check("t2_bubble", cyc, 5);
    end
    drain();
    check("t2_lerr", len_err_count, 0);

    // 60 B declared as 64, then saturation
    send_pkt(60, 64, -1, cyc);
    drain();
    check("t3_lerr1", len_err_count, 1);
    for (int p = 0; p < 299; p++) send_pkt(60, 64, -1, cyc);
    drain();
    check("t3_lerr_sat", len_err_count, 255);
    check("t3_pkts", pkt_count, model_pkts);

    // 256 B packet with toggling output ready
    rdy_mode = 1;
    send_pkt(256, 256, -1, cyc);
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset during the second data beat of a 4-beat packet
    prepare_pkt(128, 128, -1);
    drive_beat(0, cyc);
    s_tvalid = 1'b1; s_tdata = bd[1]; s_tkeep = bk[1]; s_tlast = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    model_seq = 0; model_pkts = 0; model_lerr = 0;
    check("t5_mvalid", m_tvalid, 0);
    check("t5_sready", s_tready, 0);
    check("t5_pkts", pkt_count, 0);
    check("t5_lerr", len_err_count, 0);
    rst = 1'b0;
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    send_pkt(40, 40, -1, cyc);    // header must carry seq 0
    drain();

    // sequence wrap with single-beat packets
    for (int p = 0; p < (1 << SEQ_W); p++) begin
      send_pkt(32, 32, -1, cyc);
      if (p == 0) check("t6_single", cyc, 2);
    end
    drain();
    check("t6_seq_wrapped", model_seq, 1);
    check("t6_pkts", pkt_count, model_pkts);

    // random packets, random output back-pressure
    rdy_mode = 2;
    for (int p = 0; p < 60; p++) begin
      int nbytes, decl;
      nbytes = $urandom_range(1, 300);
      decl   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 16383) : nbytes;
      send_pkt(nbytes, decl, -1, cyc);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end
    rdy_mode = 0;
    drain();
    check("rand_pkts", pkt_count, model_pkts);
    check("rand_lerr", len_err_count, model_lerr);
    check("end_queue", exp_q.size(), 0);
    report_finish();
  end

  initial begin
    #3000000;
    check("global_timeout", 1'b0, 1'b1);
    report_finish();
  end

endmodule
